// File: rtl/coherence_pkg.sv
// Shared encodings for the MSI coherence controller (line states, bus ops, snoop FSM).
package coherence_pkg;

  localparam logic [1:0] INVALID  = 2'b00;
  localparam logic [1:0] SHARED   = 2'b01;
  localparam logic [1:0] MODIFIED = 2'b10;

  localparam logic [1:0] OP_NONE    = 2'b00;
  localparam logic [1:0] OP_RD_MISS = 2'b01;
  localparam logic [1:0] OP_WR_MISS = 2'b10;
  localparam logic [1:0] OP_INV     = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StLookup = 2'b01,
    StWb     = 2'b10,
    StDone   = 2'b11
  } snoop_st_e;

endpackage

// File: rtl/snoop_line_array.sv
// Per-line tag/state storage: combinational read, CPU-side and snoop-side write ports.
module snoop_line_array
  import coherence_pkg::*;
#(
  parameter int unsigned IndexW = 2,
  parameter int unsigned TagW   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IndexW-1:0] rd_index_i,
  output logic [TagW-1:0]   rd_tag_o,
  output logic [1:0]        rd_state_o,
  input  logic              cpu_we_i,
  input  logic [IndexW-1:0] cpu_index_i,
  input  logic [TagW-1:0]   cpu_tag_i,
  input  logic [1:0]        cpu_state_i,
  input  logic              snp_we_i,
  input  logic [IndexW-1:0] snp_index_i,
  input  logic [1:0]        snp_state_i
);

  localparam int unsigned Lines = 2 ** IndexW;

  logic [TagW-1:0] tag_q   [Lines];
  logic [1:0]      state_q [Lines];

  // Snoop port only rewrites state; the tag already matches on any snoop update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Lines; i++) begin
        tag_q[i]   <= '0;
        state_q[i] <= INVALID;
      end
    end else begin
      if (cpu_we_i) begin
        tag_q[cpu_index_i]   <= cpu_tag_i;
        state_q[cpu_index_i] <= cpu_state_i;
      end
      if (snp_we_i) begin
        state_q[snp_index_i] <= snp_state_i;
      end
    end
  end

  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_state_o = state_q[rd_index_i];

endmodule

// File: rtl/sm_bus.sv
// Snoop side of the MSI controller: answers bus messages against the local line array.
module sm_bus
  import coherence_pkg::*;
#(
  parameter int unsigned INDEX_W = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               snoop_valid,
  output logic               snoop_ready,
  input  logic [1:0]         snoop_op,
  input  logic [INDEX_W-1:0] snoop_index,
  input  logic [TAG_W-1:0]   snoop_tag,
  input  logic               cpu_wr_valid,
  input  logic [INDEX_W-1:0] cpu_wr_index,
  input  logic [TAG_W-1:0]   cpu_wr_tag,
  input  logic [1:0]         cpu_wr_state,
  output logic               cpu_wr_stall,
  output logic               writeBack,
  output logic [INDEX_W-1:0] wb_index,
  output logic [TAG_W-1:0]   wb_tag,
  input  logic               wb_ack,
  output logic               abortMemoryAccess,
  output logic               snoop_done,
  output logic               snoop_hit,
  output logic               protocol_error,
  output logic [1:0]         currentState
);

  snoop_st_e          state_q;
  logic [1:0]         op_q;
  logic [INDEX_W-1:0] idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic [1:0]         cur_q;
  logic [1:0]         pend_q;
  logic               hit_q;
  logic               perr_q;

  logic [TAG_W-1:0] rd_tag;
  logic [1:0]       rd_state;
  logic             lk_hit, lk_upd, lk_wb, lk_perr;
  logic [1:0]       lk_new;
  logic             snp_we;
  logic [1:0]       snp_state;

  always_comb begin
    lk_hit  = (rd_state != INVALID) && (rd_tag == tag_q) && (op_q != OP_NONE);
    lk_upd  = 1'b0;
    lk_wb   = 1'b0;
    lk_perr = 1'b0;
    lk_new  = rd_state;
    if (lk_hit) begin
      case (op_q)
        OP_RD_MISS: begin
          if (rd_state == MODIFIED) begin
            lk_upd = 1'b1;
            lk_wb  = 1'b1;
            lk_new = SHARED;
          end
        end
        OP_WR_MISS: begin
          if (rd_state == SHARED || rd_state == MODIFIED) begin
            lk_upd = 1'b1;
            lk_wb  = (rd_state == MODIFIED);
            lk_new = INVALID;
          end
        end
        OP_INV: begin
          if (rd_state == SHARED || rd_state == MODIFIED) begin
            lk_upd  = 1'b1;
            lk_perr = (rd_state == MODIFIED);
            lk_new  = INVALID;
          end
        end
        default: ;
      endcase
    end
  end

  // Deferred update commits only on the WB->DONE edge, so a reset mid-WB leaves nothing behind.
  assign snp_we    = ((state_q == StLookup) && lk_upd && !lk_wb) ||
                     ((state_q == StWb) && wb_ack);
  assign snp_state = (state_q == StWb) ? pend_q : lk_new;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OP_NONE;
      idx_q   <= '0;
      tag_q   <= '0;
      cur_q   <= INVALID;
      pend_q  <= INVALID;
      hit_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (snoop_valid) begin
            op_q    <= snoop_op;
            idx_q   <= snoop_index;
            tag_q   <= snoop_tag;
            state_q <= StLookup;
          end
        end
        StLookup: begin
          cur_q   <= rd_state;
          hit_q   <= lk_hit;
          perr_q  <= lk_perr;
          pend_q  <= lk_new;
          state_q <= lk_wb ? StWb : StDone;
        end
        StWb: begin
          if (wb_ack) begin
            state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  snoop_line_array #(
    .IndexW (INDEX_W),
    .TagW   (TAG_W)
  ) u_array (
    .clk_i       (clock),
    .rst_i       (reset),
    .rd_index_i  (idx_q),
    .rd_tag_o    (rd_tag),
    .rd_state_o  (rd_state),
    .cpu_we_i    (cpu_wr_valid && !cpu_wr_stall),
    .cpu_index_i (cpu_wr_index),
    .cpu_tag_i   (cpu_wr_tag),
    .cpu_state_i (cpu_wr_state),
    .snp_we_i    (snp_we),
    .snp_index_i (idx_q),
    .snp_state_i (snp_state)
  );

  assign snoop_ready       = (state_q == StIdle) && !reset;
  assign writeBack         = (state_q == StWb);
  assign abortMemoryAccess = (state_q == StWb);
  assign cpu_wr_stall      = ((state_q == StLookup) || (state_q == StWb)) &&
                             (cpu_wr_index == idx_q);
  assign snoop_done        = (state_q == StDone);
  assign snoop_hit         = snoop_done && hit_q;
  assign protocol_error    = snoop_done && perr_q;
  assign currentState      = snoop_done ? cur_q : INVALID;
  assign wb_index          = idx_q;
  assign wb_tag            = tag_q;

endmodule

// File: tb/tb_sm_bus.sv
// Scoreboard bench for sm_bus: expected snoop completions queued at issue, checked on snoop_done.
module tb_sm_bus;

  localparam int unsigned IW = 2;
  localparam int unsigned TW = 4;
  localparam logic [1:0] INV = 2'b00, SHR = 2'b01, MOD = 2'b10;
  localparam logic [1:0] RD = 2'b01, WR = 2'b10, IV = 2'b11;

  logic          clock = 1'b0;
  logic          reset;
  logic          snoop_valid;
  logic          snoop_ready;
  logic [1:0]    snoop_op;
  logic [IW-1:0] snoop_index;
  logic [TW-1:0] snoop_tag;
  logic          cpu_wr_valid;
  logic [IW-1:0] cpu_wr_index;
  logic [TW-1:0] cpu_wr_tag;
  logic [1:0]    cpu_wr_state;
  logic          cpu_wr_stall;
  logic          writeBack;
  logic [IW-1:0] wb_index;
  logic [TW-1:0] wb_tag;
  logic          wb_ack;
  logic          abortMemoryAccess;
  logic          snoop_done;
  logic          snoop_hit;
  logic          protocol_error;
  logic [1:0]    currentState;

  sm_bus #(
    .INDEX_W (IW),
    .TAG_W   (TW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .snoop_valid       (snoop_valid),
    .snoop_ready       (snoop_ready),
    .snoop_op          (snoop_op),
    .snoop_index       (snoop_index),
    .snoop_tag         (snoop_tag),
    .cpu_wr_valid      (cpu_wr_valid),
    .cpu_wr_index      (cpu_wr_index),
    .cpu_wr_tag        (cpu_wr_tag),
    .cpu_wr_state      (cpu_wr_state),
    .cpu_wr_stall      (cpu_wr_stall),
    .writeBack         (writeBack),
    .wb_index          (wb_index),
    .wb_tag            (wb_tag),
    .wb_ack            (wb_ack),
    .abortMemoryAccess (abortMemoryAccess),
    .snoop_done        (snoop_done),
    .snoop_hit         (snoop_hit),
    .protocol_error    (protocol_error),
    .currentState      (currentState)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       hit;
    logic [1:0] cur;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Completion monitor: every snoop_done pops one expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (snoop_done) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("snoop_hit", int'(snoop_hit), int'(e.hit));
          check_eq("currentState", int'(currentState), int'(e.cur));
          check_eq("protocol_error", int'(protocol_error), int'(e.perr));
        end
      end else if (protocol_error) begin
        check_eq("stray_protocol_error", int'(protocol_error), 0);
      end
    end
  end

  task automatic cpu_write(input int idx, input int tag, input logic [1:0] st);
    cpu_wr_valid = 1'b1;
    cpu_wr_index = idx[IW-1:0];
    cpu_wr_tag   = tag[TW-1:0];
    cpu_wr_state = st;
    @(posedge clock);
    @(negedge clock);
    cpu_wr_valid = 1'b0;
  endtask

  // wb_cycles < 0: no write-back expected; otherwise ack after that many writeBack cycles.
  task automatic run_snoop(input logic [1:0] op, input int idx, input int tag, input logic e_hit,
                           input logic [1:0] e_cur, input logic e_perr, input int wb_cycles);
    int cycles;
    int wbseen;
    exp_t e;
    e.hit = e_hit; e.cur = e_cur; e.perr = e_perr;
    exp_q.push_back(e);
    check_eq("ready_before", int'(snoop_ready), 1);
    snoop_valid = 1'b1;
    snoop_op    = op;
    snoop_index = idx[IW-1:0];
    snoop_tag   = tag[TW-1:0];
    @(posedge clock);
    @(negedge clock);
    snoop_valid = 1'b0;
    check_eq("busy_lookup", int'(snoop_ready), 0);
    cycles = 1;
    wbseen = 0;
    while (!snoop_done && cycles < 40) begin
      check_eq("abort_eq_wb", int'(abortMemoryAccess), int'(writeBack));
      if (writeBack) begin
        wbseen++;
        check_eq("wb_index", int'(wb_index), idx);
        check_eq("wb_tag", int'(wb_tag), tag);
        if (wbseen == wb_cycles) wb_ack = 1'b1;
      end
      @(negedge clock);
      wb_ack = 1'b0;
      cycles++;
    end
    check_eq("done_seen", int'(snoop_done), 1);
    check_eq("done_latency", cycles, (wb_cycles < 0) ? 2 : wb_cycles + 2);
    check_eq("wb_cycle_count", wbseen, (wb_cycles < 0) ? 0 : wb_cycles);
    @(negedge clock);
    check_eq("ready_after", int'(snoop_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b1; snoop_valid = 1'b0; snoop_op = '0; snoop_index = '0; snoop_tag = '0;
    cpu_wr_valid = 1'b0; cpu_wr_index = '0; cpu_wr_tag = '0; cpu_wr_state = '0; wb_ack = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("ready_in_reset", int'(snoop_ready), 0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_ready", int'(snoop_ready), 1);
    check_eq("rst_wb", int'(writeBack), 0);
    check_eq("rst_abort", int'(abortMemoryAccess), 0);
    check_eq("rst_done", int'(snoop_done), 0);
    check_eq("rst_stall", int'(cpu_wr_stall), 0);
    check_eq("rst_wb_index", int'(wb_index), 0);
    check_eq("rst_cur", int'(currentState), 0);

    // Shared read-miss hit, then probe that the line is still Shared.
    cpu_write(1, 5, SHR);
    run_snoop(RD, 1, 5, 1'b1, SHR, 1'b0, -1);
    run_snoop(RD, 1, 5, 1'b1, SHR, 1'b0, -1);
    // Reserved op: no hit reported, no change.
    run_snoop(2'b00, 1, 5, 1'b0, SHR, 1'b0, -1);
    run_snoop(RD, 1, 5, 1'b1, SHR, 1'b0, -1);

    // Write miss on Modified: write-back, then Invalid.
    cpu_write(2, 3, MOD);
    run_snoop(WR, 2, 3, 1'b1, MOD, 1'b0, 3);
    run_snoop(RD, 2, 3, 1'b0, INV, 1'b0, -1);

    // Tag mismatch leaves the line alone.
    cpu_write(0, 7, SHR);
    run_snoop(IV, 0, 6, 1'b0, SHR, 1'b0, -1);
    run_snoop(RD, 0, 7, 1'b1, SHR, 1'b0, -1);
    // Write miss on Shared invalidates without write-back.
    run_snoop(WR, 0, 7, 1'b1, SHR, 1'b0, -1);
    run_snoop(RD, 0, 7, 1'b0, INV, 1'b0, -1);

    // Read miss on Modified with CPU traffic during WB.
    cpu_write(2, 3, MOD);
    fork
      run_snoop(RD, 2, 3, 1'b1, MOD, 1'b0, 3);
      begin
        cyc = 0;
        while (!writeBack && cyc < 20) begin
          @(negedge clock);
          cyc++;
        end
        check_eq("wb_window_seen", int'(writeBack), 1);
        cpu_wr_valid = 1'b1; cpu_wr_index = 2'd3; cpu_wr_tag = 4'd9; cpu_wr_state = MOD;
        #1 check_eq("stall_other_index", int'(cpu_wr_stall), 0);
        @(negedge clock);
        cpu_wr_index = 2'd2; cpu_wr_tag = 4'd4; cpu_wr_state = SHR;
        #1 check_eq("stall_same_index", int'(cpu_wr_stall), 1);
        cyc = 0;
        while (!snoop_done && cyc < 20) begin
          @(negedge clock);
          #1;
          if (!snoop_done) check_eq("stall_held", int'(cpu_wr_stall), 1);
          cyc++;
        end
        check_eq("stall_released", int'(cpu_wr_stall), 0);
        @(posedge clock);
        @(negedge clock);
        cpu_wr_valid = 1'b0;
      end
    join
    run_snoop(RD, 2, 4, 1'b1, SHR, 1'b0, -1);
    // Index 3 was written during WB as Modified: invalidate flags a protocol error.
    run_snoop(IV, 3, 9, 1'b1, MOD, 1'b1, -1);
    run_snoop(RD, 3, 9, 1'b0, INV, 1'b0, -1);

    // Reset in the middle of a write-back.
    cpu_write(0, 2, MOD);
    snoop_valid = 1'b1; snoop_op = WR; snoop_index = 2'd0; snoop_tag = 4'd2;
    @(posedge clock);
    @(negedge clock);
    snoop_valid = 1'b0;
    cyc = 0;
    while (!writeBack && cyc < 10) begin
      @(negedge clock);
      cyc++;
    end
    check_eq("wb_before_reset", int'(writeBack), 1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_eq("wb_dropped", int'(writeBack), 0);
    check_eq("ready_held_in_reset", int'(snoop_ready), 0);
    reset = 1'b0;
    #1 check_eq("ready_after_reset", int'(snoop_ready), 1);
    @(negedge clock);
    run_snoop(RD, 1, 5, 1'b0, INV, 1'b0, -1);
    run_snoop(RD, 2, 4, 1'b0, INV, 1'b0, -1);
    run_snoop(RD, 0, 2, 1'b0, INV, 1'b0, -1);

    repeat (2) @(negedge clock);
    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
